// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: read ports, two write ports, pending-claim port and count.
// master = pipeline side, slave = register file.
interface reg_file_mp_if #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 5,
  parameter int NUM_RD   = 2
);
  logic [NUM_RD*ADDR_LEN-1:0] rd_addr;
  logic [NUM_RD*XLEN-1:0]     rd_data;
  logic [NUM_RD-1:0]          rd_busy;

  logic                       wr0_en;
  logic [ADDR_LEN-1:0]        wr0_addr;
  logic [XLEN-1:0]            wr0_data;

  logic                       wr1_en;
  logic [ADDR_LEN-1:0]        wr1_addr;
  logic [XLEN-1:0]            wr1_data;

  logic                       claim_en;
  logic [ADDR_LEN-1:0]        claim_addr;

  logic [ADDR_LEN:0]          pend_cnt;

  modport master (
    output rd_addr,
    output wr0_en, wr0_addr, wr0_data,
    output wr1_en, wr1_addr, wr1_data,
    output claim_en, claim_addr,
    input  rd_data, rd_busy, pend_cnt
  );

  modport slave (
    input  rd_addr,
    input  wr0_en, wr0_addr, wr0_data,
    input  wr1_en, wr1_addr, wr1_data,
    input  claim_en, claim_addr,
    output rd_data, rd_busy, pend_cnt
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with late-writeback pending scoreboard; x0 reads as zero.
// Optional macro REG_BYPASS_EN: same-cycle write data is forwarded to matching read ports.
module reg_file_mp #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 5,
  parameter int NUM_RD   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_mp_if.slave  bus
);

  localparam int NUM_REGS = 2**ADDR_LEN;
  localparam logic [ADDR_LEN:0] CNT_ONE = {{ADDR_LEN{1'b0}}, 1'b1};

  logic [XLEN-1:0]      r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]  r_pend;
  logic [ADDR_LEN:0]    r_pend_cnt;

  logic                 w_wr0_hit;
  logic                 w_wr1_hit;
  logic                 w_set;
  logic                 w_clr;
  logic                 w_cnt_inc;
  logic                 w_cnt_dec;
  logic [NUM_REGS-1:0]  w_pend_nxt;
  logic [NUM_RD*XLEN-1:0] w_rd_data;
  logic [NUM_RD-1:0]    w_rd_busy;

  assign w_wr0_hit = bus.wr0_en   && (bus.wr0_addr   != '0);
  assign w_wr1_hit = bus.wr1_en   && (bus.wr1_addr   != '0);
  assign w_set     = bus.claim_en && (bus.claim_addr != '0);
  assign w_clr     = w_wr1_hit;

  // Storage: W1 then W0 in program order, so W0 wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
    end else begin
      if (w_wr1_hit) r_regs[bus.wr1_addr] <= bus.wr1_data;
      if (w_wr0_hit) r_regs[bus.wr0_addr] <= bus.wr0_data;
    end
  end

  // Claim applied after clear: a new producer overrides the returning result.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_clr) w_pend_nxt[bus.wr1_addr]   = 1'b0;
    if (w_set) w_pend_nxt[bus.claim_addr] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  assign w_cnt_inc = w_set && !r_pend[bus.claim_addr];
  assign w_cnt_dec = w_clr && r_pend[bus.wr1_addr] &&
                     !(w_set && (bus.claim_addr == bus.wr1_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_cnt_inc && !w_cnt_dec)
        r_pend_cnt <= r_pend_cnt + CNT_ONE;
      else if (w_cnt_dec && !w_cnt_inc)
        r_pend_cnt <= r_pend_cnt - CNT_ONE;
    end
  end

  function automatic logic [XLEN-1:0] read_value(input logic [ADDR_LEN-1:0] a);
    logic [XLEN-1:0] v;
    v = r_regs[a];
`ifdef REG_BYPASS_EN
    if (w_wr0_hit && (bus.wr0_addr == a))
      v = bus.wr0_data;
    else if (w_wr1_hit && (bus.wr1_addr == a))
      v = bus.wr1_data;
`endif
    if (a == '0) v = '0;
    return v;
  endfunction

  function automatic logic read_busy(input logic [ADDR_LEN-1:0] a);
    logic b;
    b = r_pend[a];
`ifdef REG_BYPASS_EN
    if (w_wr1_hit && (bus.wr1_addr == a) && !(w_set && (bus.claim_addr == a)))
      b = 1'b0;
`endif
    if (a == '0) b = 1'b0;
    return b;
  endfunction

  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_rd_data[i*XLEN +: XLEN] = read_value(bus.rd_addr[i*ADDR_LEN +: ADDR_LEN]);
      w_rd_busy[i]              = read_busy(bus.rd_addr[i*ADDR_LEN +: ADDR_LEN]);
    end
  end

  assign bus.rd_data  = w_rd_data;
  assign bus.rd_busy  = w_rd_busy;
  assign bus.pend_cnt = r_pend_cnt;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: driver pushes model expectations, monitor compares at negedge.
// Honours REG_BYPASS_EN in the reference model when the macro is defined.
module tb_reg_file_mp;

  localparam int XLEN     = 32;
  localparam int ADDR_LEN = 5;
  localparam int NUM_RD   = 2;
  localparam int NUM_REGS = 2**ADDR_LEN;

  logic clk;
  logic rst_n;

  reg_file_mp_if #(.XLEN(XLEN), .ADDR_LEN(ADDR_LEN), .NUM_RD(NUM_RD)) bus ();

  reg_file_mp #(.XLEN(XLEN), .ADDR_LEN(ADDR_LEN), .NUM_RD(NUM_RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                     step;
    logic [NUM_RD*XLEN-1:0] data;
    logic [NUM_RD-1:0]      busy;
    logic [ADDR_LEN:0]      cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step     = 0;

  // Reference state: plain arrays, count derived by counting.
  logic [XLEN-1:0] m_regs [NUM_REGS];
  bit              m_pend [NUM_REGS];

  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
  endtask

  task automatic model_commit();
    if (bus.wr1_en && bus.wr1_addr != 0) m_regs[bus.wr1_addr] = bus.wr1_data;
    if (bus.wr0_en && bus.wr0_addr != 0) m_regs[bus.wr0_addr] = bus.wr0_data;
    if (bus.wr1_en) m_pend[bus.wr1_addr] = 1'b0;
    if (bus.claim_en && bus.claim_addr != 0) m_pend[bus.claim_addr] = 1'b1;
  endtask

  function automatic int model_count();
    int c = 0;
    for (int r = 0; r < NUM_REGS; r++) if (m_pend[r]) c++;
    return c;
  endfunction

  task automatic push_expect();
    exp_t e;
    int   a;
    e.step = step;
    e.data = '0;
    e.busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = int'(bus.rd_addr[i*ADDR_LEN +: ADDR_LEN]);
      if (a != 0) begin
        e.data[i*XLEN +: XLEN] = m_regs[a];
        e.busy[i]              = m_pend[a];
`ifdef REG_BYPASS_EN
        if (bus.wr0_en && int'(bus.wr0_addr) == a)
          e.data[i*XLEN +: XLEN] = bus.wr0_data;
        else if (bus.wr1_en && int'(bus.wr1_addr) == a)
          e.data[i*XLEN +: XLEN] = bus.wr1_data;
        if (bus.wr1_en && int'(bus.wr1_addr) == a &&
            !(bus.claim_en && int'(bus.claim_addr) == a))
          e.busy[i] = 1'b0;
`endif
      end
    end
    e.cnt = (ADDR_LEN+1)'(model_count());
    q.push_back(e);
  endtask

  // Inputs are live from posedge+1; the expectation is pushed, then the edge commits.
  task automatic cycle();
    push_expect();
    step++;
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    bus.wr0_en = 1'b0; bus.wr0_addr = '0; bus.wr0_data = '0;
    bus.wr1_en = 1'b0; bus.wr1_addr = '0; bus.wr1_data = '0;
    bus.claim_en = 1'b0; bus.claim_addr = '0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    bus.rd_addr[0 +: ADDR_LEN]        = ADDR_LEN'(a0);
    bus.rd_addr[ADDR_LEN +: ADDR_LEN] = ADDR_LEN'(a1);
  endtask

  function automatic int rand_addr();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NUM_REGS-1));
    return int'($urandom_range(0, 7));
  endfunction

  // Monitor: compares whatever expectation is outstanding at each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < NUM_RD; i++) begin
          n_checks++;
          if (bus.rd_data[i*XLEN +: XLEN] !== e.data[i*XLEN +: XLEN]) begin
            n_fail++;
            $display("FAIL rd_data step=%0d port=%0d got=%h exp=%h", e.step, i,
                     bus.rd_data[i*XLEN +: XLEN], e.data[i*XLEN +: XLEN]);
          end
          n_checks++;
          if (bus.rd_busy[i] !== e.busy[i]) begin
            n_fail++;
            $display("FAIL rd_busy step=%0d port=%0d got=%b exp=%b", e.step, i,
                     bus.rd_busy[i], e.busy[i]);
          end
        end
        n_checks++;
        if (bus.pend_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL pend_cnt step=%0d got=%0d exp=%0d", e.step, bus.pend_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog expired at step %0d", step);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    set_rd(0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int a = 0; a < NUM_REGS; a++) begin
      set_rd(a, NUM_REGS-1-a);
      cycle();
    end

    idle(); bus.wr0_en = 1'b1; bus.wr0_addr = 5'd5; bus.wr0_data = 32'hDEADBEEF; cycle();
    idle(); bus.wr0_en = 1'b1; bus.wr0_addr = 5'd0; bus.wr0_data = 32'h1234;     cycle();
    idle(); set_rd(5, 0); cycle();

    idle(); bus.wr0_en = 1'b1; bus.wr0_addr = 5'd7; bus.wr0_data = 32'h11;
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd7; bus.wr1_data = 32'h22; set_rd(7, 7); cycle();
    idle(); cycle();

    set_rd(3, 7);
    idle(); bus.claim_en = 1'b1; bus.claim_addr = 5'd3; cycle();
    idle(); cycle();
    bus.claim_en = 1'b1; bus.claim_addr = 5'd3;
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd3; bus.wr1_data = 32'h55; cycle();
    idle(); cycle();
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd3; bus.wr1_data = 32'h55; cycle();
    idle(); cycle();

    for (int a = 1; a < NUM_REGS; a++) begin
      idle(); bus.claim_en = 1'b1; bus.claim_addr = ADDR_LEN'(a); set_rd(a, 5); cycle();
    end
    idle(); set_rd(5, 7); cycle();
    cycle();

    // Asynchronous reset between edges: expectations checked before the next edge.
    rst_n = 1'b0;
    model_reset();
    push_expect();
    step++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    idle(); bus.wr0_en = 1'b1; bus.wr0_addr = 5'd9; bus.wr0_data = 32'h1111; cycle();
    idle(); bus.wr1_en = 1'b1; bus.wr1_addr = 5'd9; bus.wr1_data = 32'hA5A5; set_rd(9, 0); cycle();
    idle(); cycle();

    for (int n = 0; n < 600; n++) begin
      bus.wr0_en     = ($urandom_range(0, 1) == 1);
      bus.wr0_addr   = ADDR_LEN'(rand_addr());
      bus.wr0_data   = $urandom;
      bus.wr1_en     = ($urandom_range(0, 2) == 0);
      bus.wr1_addr   = ADDR_LEN'(rand_addr());
      bus.wr1_data   = $urandom;
      bus.claim_en   = ($urandom_range(0, 2) == 0);
      bus.claim_addr = ADDR_LEN'(rand_addr());
      set_rd(rand_addr(), rand_addr());
      cycle();
    end

    idle();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port integer register file for the rysyCore successor pipeline. It provides NUM_RD combinational read ports and two write ports: W0 for ALU writeback and W1 for late writeback from load or multi-cycle units. A per-register pending scoreboard lets decode detect reads of registers whose late result has not yet returned. x0 stays hardwired to zero on every path.

Parameters:
XLEN, 32, data width of each register
ADDR_LEN, 5, register address width; register count NUM_REGS = 2**ADDR_LEN
NUM_RD, 2, number of read ports (1..4)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
rd_addr  in  NUM_RD*ADDR_LEN  read addresses, port i at bits [i*ADDR_LEN +: ADDR_LEN]
rd_data  out  NUM_RD*XLEN  read data, port i at bits [i*XLEN +: XLEN]
rd_busy  out  NUM_RD  port i addresses a register with a pending late write
wr0_en  in  1  ALU writeback enable
wr0_addr  in  ADDR_LEN  ALU writeback address
wr0_data  in  XLEN  ALU writeback data
wr1_en  in  1  late writeback enable; also clears the pending bit
wr1_addr  in  ADDR_LEN  late writeback address
wr1_data  in  XLEN  late writeback data
claim_en  in  1  mark a register pending (late-result instruction issued)
claim_addr  in  ADDR_LEN  register to mark
pend_cnt  out  ADDR_LEN+1  number of registers currently pending

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, independent of clk): all registers clear to 0; all pending bits clear to 0; pend_cnt=0. A reset asserted mid-operation discards in-flight claims immediately.
- Reads are combinational, with zero latency.
  - rd_data[i] = 0 when rd_addr[i]==0; otherwise the stored value (see the optional bypass).
  - rd_busy[i] = pend[rd_addr[i]]; it is always 0 for address 0.
- Writes commit on the rising clk edge.
  - Writes to address 0 are ignored by both ports.
  - W0 and W1 to the same nonzero address in one cycle: the W0 data is stored.
- Pending scoreboard, bit pend[r] per register:
  - Set: claim_en with claim_addr!=0 sets the bit at the next edge.
  - Clear: wr1_en clears pend[wr1_addr] at the next edge.
  - wr0_en never changes pending bits.
  - claim and wr1 to the same address in one cycle: the claim wins and the bit ends at 1 (a new producer was issued).
  - claim of an already-pending register: the bit stays 1 and pend_cnt is unchanged.
  - wr1 to a non-pending register: the data is written and the bit stays 0.
- pend_cnt is registered and always equals popcount(pend).
  - It changes by -1, 0 or +1 per cycle, computed from the next-state set/clear decisions.
  - It never wraps; its maximum is NUM_REGS-1 because x0 is never pending.

Optional Feature:
REG_BYPASS_EN
- Defined: a read whose address matches an active same-cycle write returns the write data combinationally.
  - W0 has priority over W1, consistent with the storage rule.
  - rd_busy[i] is forced to 0 when a same-cycle wr1 matches rd_addr[i] and no claim to that address occurs that cycle.
  - Address 0 still reads 0.
- Undefined: reads return only stored values, so written data is visible from the cycle after the edge. rd_busy reflects registered pend only.

Test Plan:
- Release reset, then read all 32 addresses on both ports -> all rd_data=0, rd_busy=0, pend_cnt=0.
- wr0 x5=0xDEADBEEF and wr0 x0=0x1234, then read x5 and x0 the next cycle -> 0xDEADBEEF and 0.
- Same cycle: wr0 x7=0x11 and wr1 x7=0x22, then read x7 -> 0x11.
- Claim x3 -> rd_busy=1 and pend_cnt=1. Then claim x3 and wr1 x3=0x55 in the same cycle -> busy stays 1, x3=0x55, pend_cnt=1. Then wr1 x3 alone -> busy 0, pend_cnt 0.
- Claim x1..x31 on consecutive cycles -> pend_cnt reaches 31. Assert rst_n=0 between edges -> pend_cnt=0 and rd_data=0 without a clock edge.
- With REG_BYPASS_EN: wr1 x9=0xA5A5 while rd_addr=9 in the same cycle -> rd_data=0xA5A5 that cycle. Without the macro -> old value that cycle, 0xA5A5 the next.
